// File: rtl/mips_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_core_pkg
// Purpose  : Shared types for the rename-stage physical register free list.
// Revision : 1.0 - initial release
// ============================================================================
package mips_core_pkg;

    typedef enum logic [1:0] {
        PICK_LOW  = 2'd0,
        PICK_HIGH = 2'd1,
        PICK_RR   = 2'd2
    } pick_mode_e;

endpackage
`default_nettype wire

// File: rtl/prio_enc_param.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc_param
// Purpose  : Parameterised combinational priority encoder, LSB- or MSB-first.
// Revision : 1.0 - initial release
// ============================================================================
module prio_enc_param #(
    parameter int N          = 64,
    parameter bit HIGH_FIRST = 1'b0,
    localparam int W         = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);

    // The last matching assignment wins, so the scan direction sets priority.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    found = 1'b1;
                    idx   = W'(i);
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) begin
                    found = 1'b1;
                    idx   = W'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/phys_reg_free_list.sv
`default_nettype none
// ============================================================================
// Module   : phys_reg_free_list
// Purpose  : Bitmap free list with a registered pre-selected allocation slot.
// Revision : 1.0 - initial release
// ============================================================================
module phys_reg_free_list
    import mips_core_pkg::*;
#(
    parameter int         NUM_ENTRIES  = 64,
    parameter int         IDX_W        = $clog2(NUM_ENTRIES),
    parameter int         NUM_RESERVED = 32,
    parameter pick_mode_e PICK_MODE    = PICK_LOW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   alloc_valid,
    output logic [IDX_W-1:0]       alloc_idx,
    input  logic                   alloc_ready,
    input  logic                   rel_valid,
    input  logic [IDX_W-1:0]       rel_idx,
    input  logic                   recover_valid,
    input  logic [NUM_ENTRIES-1:0] recover_mask,
    output logic [IDX_W:0]         free_count,
    output logic                   err_double_free
);

    localparam logic [NUM_ENTRIES-1:0] c_reset_free  = {NUM_ENTRIES{1'b1}} << NUM_RESERVED;
    localparam logic [IDX_W:0]         c_reset_count = (IDX_W+1)'(NUM_ENTRIES - NUM_RESERVED);

    logic [NUM_ENTRIES-1:0] r_free;
    logic                   r_cand_valid;
    logic [IDX_W-1:0]       r_cand_idx;
    logic [IDX_W:0]         r_count;
    logic                   r_err;

    logic                   w_fire;
    logic                   w_refill;
    logic                   w_found;
    logic [IDX_W-1:0]       w_pick;
    logic                   w_take;
    logic                   w_rel_ok;
    logic [NUM_ENTRIES-1:0] w_free_next;
    logic [IDX_W:0]         w_rec_count;

    assign w_fire   = r_cand_valid && alloc_ready;
    assign w_refill = !r_cand_valid || w_fire;
    assign w_take   = w_refill && w_found;

    // A release is legal only for an index neither free nor parked in the slot.
    always_comb begin
        w_rel_ok = rel_valid && !r_free[rel_idx] &&
                   !(r_cand_valid && (rel_idx == r_cand_idx));
        w_free_next = r_free;
        if (w_take)
            w_free_next[w_pick] = 1'b0;
        if (w_rel_ok)
            w_free_next[rel_idx] = 1'b1;
        w_rec_count = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            w_rec_count = w_rec_count + (IDX_W+1)'(recover_mask[i]);
    end

    generate
        if (PICK_MODE == PICK_RR) begin : g_rr
            logic [IDX_W-1:0]       r_last;
            logic [NUM_ENTRIES-1:0] w_masked;
            logic                   w_m_found;
            logic                   w_f_found;
            logic [IDX_W-1:0]       w_m_idx;
            logic [IDX_W-1:0]       w_f_idx;

            always_comb begin
                w_masked = '0;
                for (int i = 0; i < NUM_ENTRIES; i++)
                    w_masked[i] = r_free[i] && (IDX_W'(i) > r_last);
            end

            prio_enc_param #(.N(NUM_ENTRIES), .HIGH_FIRST(1'b0)) u_enc_masked (
                .req   (w_masked),
                .found (w_m_found),
                .idx   (w_m_idx)
            );

            prio_enc_param #(.N(NUM_ENTRIES), .HIGH_FIRST(1'b0)) u_enc_full (
                .req   (r_free),
                .found (w_f_found),
                .idx   (w_f_idx)
            );

            assign w_found = w_m_found || w_f_found;
            assign w_pick  = w_m_found ? w_m_idx : w_f_idx;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_last <= IDX_W'(NUM_ENTRIES - 1);
                else if (!recover_valid && w_fire)
                    r_last <= r_cand_idx;
            end
        end else begin : g_single
            prio_enc_param #(
                .N          (NUM_ENTRIES),
                .HIGH_FIRST (PICK_MODE == PICK_HIGH)
            ) u_enc (
                .req   (r_free),
                .found (w_found),
                .idx   (w_pick)
            );
        end
    endgenerate

    // Recovery overrides every other update and skips the double-free check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_free       <= c_reset_free;
            r_cand_valid <= 1'b0;
            r_cand_idx   <= '0;
            r_count      <= c_reset_count;
            r_err        <= 1'b0;
        end else if (recover_valid) begin
            r_free       <= recover_mask;
            r_cand_valid <= 1'b0;
            r_count      <= w_rec_count;
        end else begin
            r_free  <= w_free_next;
            r_count <= r_count + (IDX_W+1)'(w_rel_ok) - (IDX_W+1)'(w_take);
            if (w_refill) begin
                r_cand_valid <= w_found;
                if (w_found)
                    r_cand_idx <= w_pick;
            end
            if (rel_valid && !w_rel_ok)
                r_err <= 1'b1;
        end
    end

    assign alloc_valid     = r_cand_valid;
    assign alloc_idx       = r_cand_idx;
    assign free_count      = r_count + (IDX_W+1)'(r_cand_valid);
    assign err_double_free = r_err;

    a_rel_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
        rel_valid |-> (32'(rel_idx) < NUM_ENTRIES));

endmodule
`default_nettype wire

// File: tb/tb_phys_reg_free_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_phys_reg_free_list
// Purpose  : Self-checking bench for phys_reg_free_list (LOW, HIGH, RR picks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_phys_reg_free_list;
    import mips_core_pkg::*;

    typedef struct {
        logic        ready;
        logic        rel_v;
        logic [5:0]  rel_i;
        logic        rec_v;
        logic [63:0] mask;
        logic        exp_valid;
        logic [5:0]  exp_idx;
        logic [6:0]  exp_count;
        logic        exp_err;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        ready, rel_v, rec_v;
    logic [5:0]  rel_i;
    logic [63:0] rec_m;
    logic        valid, err;
    logic [5:0]  idx;
    logic [6:0]  count;

    logic        ready_h, rel_v_h, valid_h, err_h;
    logic [5:0]  rel_i_h, idx_h;
    logic [6:0]  count_h;
    logic        ready_r, rel_v_r, valid_r, err_r;
    logic [5:0]  rel_i_r, idx_r;
    logic [6:0]  count_r;
    logic        rec_off = 1'b0;
    logic [63:0] mask_off = 64'd0;

    phys_reg_free_list #(.NUM_ENTRIES(64), .NUM_RESERVED(32), .PICK_MODE(PICK_LOW)) u_low (
        .clk(clk), .rst_n(rst_n), .alloc_valid(valid), .alloc_idx(idx), .alloc_ready(ready),
        .rel_valid(rel_v), .rel_idx(rel_i), .recover_valid(rec_v), .recover_mask(rec_m),
        .free_count(count), .err_double_free(err)
    );

    phys_reg_free_list #(.NUM_ENTRIES(64), .NUM_RESERVED(32), .PICK_MODE(PICK_HIGH)) u_high (
        .clk(clk), .rst_n(rst_n), .alloc_valid(valid_h), .alloc_idx(idx_h), .alloc_ready(ready_h),
        .rel_valid(rel_v_h), .rel_idx(rel_i_h), .recover_valid(rec_off), .recover_mask(mask_off),
        .free_count(count_h), .err_double_free(err_h)
    );

    phys_reg_free_list #(.NUM_ENTRIES(64), .NUM_RESERVED(32), .PICK_MODE(PICK_RR)) u_rr (
        .clk(clk), .rst_n(rst_n), .alloc_valid(valid_r), .alloc_idx(idx_r), .alloc_ready(ready_r),
        .rel_valid(rel_v_r), .rel_idx(rel_i_r), .recover_valid(rec_off), .recover_mask(mask_off),
        .free_count(count_r), .err_double_free(err_r)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic rdy, input logic rv,
                                input logic [5:0] ri, input logic cv, input logic [63:0] m,
                                input logic ev, input logic [5:0] ei, input logic [6:0] ec,
                                input logic ee);
        vec_t v;
        v.name = name; v.ready = rdy; v.rel_v = rv; v.rel_i = ri; v.rec_v = cv; v.mask = m;
        v.exp_valid = ev; v.exp_idx = ei; v.exp_count = ec; v.exp_err = ee;
        return v;
    endfunction

    vec_t vecs[$];
    vec_t sb[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t e;
        ready = 0; rel_v = 0; rel_i = 0; rec_v = 0; rec_m = 0;
        ready_h = 0; rel_v_h = 0; rel_i_h = 0;
        ready_r = 0; rel_v_r = 0; rel_i_r = 0;

        vecs.push_back(mk("first_cand", 0, 0, 0, 0, 0, 1, 6'd32, 7'd32, 0));
        for (int k = 1; k <= 40; k++)
            vecs.push_back(mk($sformatf("burst%0d", k), 1, 0, 0, 0, 0,
                              k < 32, 6'(32 + k), (k < 32) ? 7'(32 - k) : 7'd0, 0));
        vecs.push_back(mk("rel40",       0, 1, 6'd40, 0, 0, 0, 6'd0,  7'd1,  0));
        vecs.push_back(mk("rel40_vis",   0, 0, 6'd0,  0, 0, 1, 6'd40, 7'd1,  0));
        vecs.push_back(mk("rel33",       0, 1, 6'd33, 0, 0, 1, 6'd40, 7'd2,  0));
        vecs.push_back(mk("dbl33",       0, 1, 6'd33, 0, 0, 1, 6'd40, 7'd2,  1));
        vecs.push_back(mk("dbl_cand",    0, 1, 6'd40, 0, 0, 1, 6'd40, 7'd2,  1));
        vecs.push_back(mk("err_sticky",  0, 0, 6'd0,  0, 0, 1, 6'd40, 7'd2,  1));
        vecs.push_back(mk("recover",     1, 1, 6'd5,  1, 64'hFFFF_0000_0000_0000,
                          0, 6'd0, 7'd16, 1));
        vecs.push_back(mk("rec_refill",  0, 0, 6'd0,  0, 0, 1, 6'd48, 7'd16, 1));
        vecs.push_back(mk("rel5_legal",  0, 1, 6'd5,  0, 0, 1, 6'd48, 7'd17, 1));
        vecs.push_back(mk("pick_low5",   1, 0, 6'd0,  0, 0, 1, 6'd5,  7'd16, 1));

        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_count", 64'(count), 64'd32);
        check("reset_err",   64'(err),   64'd0);
        rst_n = 1'b1;

        foreach (vecs[j]) begin
            ready = vecs[j].ready; rel_v = vecs[j].rel_v; rel_i = vecs[j].rel_i;
            rec_v = vecs[j].rec_v; rec_m = vecs[j].mask;
            sb.push_back(vecs[j]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check({e.name, "_valid"}, 64'(valid), 64'(e.exp_valid));
            if (e.exp_valid)
                check({e.name, "_idx"}, 64'(idx), 64'(e.exp_idx));
            check({e.name, "_count"}, 64'(count), 64'(e.exp_count));
            check({e.name, "_err"},   64'(err),   64'(e.exp_err));
        end
        ready = 0; rel_v = 0; rec_v = 0;

        // Asynchronous reset in the middle of an allocation burst.
        ready = 1;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_valid", 64'(valid), 64'd0);
        check("async_count", 64'(count), 64'd32);
        check("async_err",   64'(err),   64'd0);
        check("async_idx",   64'(idx),   64'd0);
        ready = 0;
        @(posedge clk);
        #1;
        check("async_hold_valid", 64'(valid), 64'd0);
        rst_n = 1'b1;

        @(posedge clk);
        #1;
        check("low_restart_idx", 64'(idx),     64'd32);
        check("high_first_idx",  64'(idx_h),   64'd63);
        check("high_first_cnt",  64'(count_h), 64'd32);
        check("rr_first_idx",    64'(idx_r),   64'd32);

        ready_h = 1; ready_r = 1;
        @(posedge clk);
        #1;
        check("high_second_idx", 64'(idx_h),   64'd62);
        check("high_second_cnt", 64'(count_h), 64'd31);
        check("rr_second_idx",   64'(idx_r),   64'd33);
        check("rr_second_cnt",   64'(count_r), 64'd31);

        ready_h = 0; ready_r = 0; rel_v_r = 1; rel_i_r = 6'd32;
        @(posedge clk);
        #1;
        check("rr_rel32_cnt", 64'(count_r), 64'd32);
        check("rr_rel32_err", 64'(err_r),   64'd0);
        check("rr_take_idx",  64'(idx_r),   64'd33);

        rel_v_r = 0; ready_r = 1;
        @(posedge clk);
        #1;
        check("rr_skip_low_idx", 64'(idx_r),   64'd34);
        check("rr_skip_low_cnt", 64'(count_r), 64'd31);
        ready_r = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
